// File: rtl/hub75_fb_arbiter_if.sv
// Bus bundle between the panel read path, the host write path, the swap
// control, the framebuffer RAM and the arbiter that shares the RAM among them.
interface hub75_fb_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24
);
  // Panel read path
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  // Host write path
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  // Bank swap control
  logic              swap_req;
  logic              frame_begin;
  logic              swap_pending;
  logic              swap_done;
  logic              front_bank;
  // Framebuffer RAM port
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Requesters and RAM as seen from outside the arbiter.
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, swap_req, frame_begin, ram_rdata,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, swap_pending, swap_done, front_bank,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  // The arbiter itself.
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, swap_req, frame_begin, ram_rdata,
    output rd_gnt, rd_valid, rd_data, wr_gnt, swap_pending, swap_done, front_bank,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/hub75_fb_arbiter.sv
// Shares one single-port framebuffer RAM between panel reads (front bank) and
// host writes (back bank). Reads have priority, but a waiting write is forced
// through after MAX_RD_BURST consecutive reads. Banks swap only at a frame
// boundary, once no read is in flight.
module hub75_fb_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 24,
  parameter int MAX_RD_BURST = 8
) (
  input logic                sys_clk,
  input logic                rst_n,
  hub75_fb_arbiter_if.slave  bus
);

  localparam int STREAK_W = $clog2(MAX_RD_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_BURST);

  typedef enum logic [1:0] {ARB_IDLE, ARB_RD, ARB_WR} arb_state_t;
  typedef enum logic [1:0] {SW_IDLE, SW_PEND, SW_DRAIN} sw_state_t;

  arb_state_t          arb_state, arb_next;
  sw_state_t           sw_state, sw_next;
  logic [STREAK_W-1:0] streak;
  logic                rd_ok, wr_elig, rd_win, wr_win, drained;

  // ---------------------------------------------------------------- arbiter

  // Arbiter state register: remembers which operation was granted last cycle.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of the order in which blocks are evaluated.
    if (!rst_n) arb_state <= ARB_IDLE;
    else        arb_state <= arb_next;
  end

  // Grant decision: reads win unless a write has waited a full read burst.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    rd_ok      = bus.rd_req && (sw_state != SW_DRAIN);
    // Writes are held off from the swap_req cycle until the cycle after swap_done.
    wr_elig    = bus.wr_req && !bus.swap_pending && !bus.swap_req;
    wr_win     = wr_elig && (!rd_ok || streak >= STREAK_MAX);
    rd_win     = rd_ok && !wr_win;
    // Grants are forced low while reset is asserted.
    bus.rd_gnt = rd_win && rst_n;
    bus.wr_gnt = wr_win && rst_n;
  end

  // Next arbiter state follows this cycle's grant.
  always_comb begin
    arb_next = ARB_IDLE;
    if (rd_win)      arb_next = ARB_RD;
    else if (wr_win) arb_next = ARB_WR;
  end

  // Read-streak counter: counts reads granted over a waiting write.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                streak <= '0;
    else if (rd_win && wr_elig) streak <= (streak >= STREAK_MAX) ? streak : streak + 1'b1;
    else                       streak <= '0;
  end

  // RAM command register and read-response pipeline.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      bus.ram_en   <= rd_win || wr_win;
      bus.ram_we   <= wr_win;
      // A read registered last cycle returns its RAM data this cycle.
      bus.rd_valid <= (arb_state == ARB_RD);
      if (rd_win) begin
        bus.ram_addr <= {bus.front_bank, bus.rd_addr};
      end else if (wr_win) begin
        bus.ram_addr  <= {~bus.front_bank, bus.wr_addr};
        bus.ram_wdata <= bus.wr_data;
      end
    end
  end

  // RAM data is passed through only while it belongs to a read.
  assign bus.rd_data = bus.rd_valid ? bus.ram_rdata : '0;

  // -------------------------------------------------------------- bank swap

  // Nothing in flight: no read on the RAM port and no response due.
  assign drained = (arb_state != ARB_RD) && !bus.rd_valid;

  // Swap state register and front-bank pointer.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_state       <= SW_IDLE;
      bus.front_bank <= 1'b0;
    end else begin
      sw_state <= sw_next;
      if (bus.swap_done) bus.front_bank <= ~bus.front_bank;
    end
  end

  // Swap sequencing: wait for a frame boundary, then for reads to drain.
  always_comb begin
    sw_next = sw_state;
    unique case (sw_state)
      SW_IDLE:  if (bus.swap_req)    sw_next = bus.frame_begin ? SW_DRAIN : SW_PEND;
      SW_PEND:  if (bus.frame_begin) sw_next = SW_DRAIN;
      SW_DRAIN: if (drained)         sw_next = SW_IDLE;
      default:                       sw_next = SW_IDLE;
    endcase
  end

  // Swap status outputs decoded from the swap state.
  always_comb begin
    bus.swap_pending = (sw_state != SW_IDLE);
    bus.swap_done    = (sw_state == SW_DRAIN) && drained;
  end

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Directed bench for hub75_fb_arbiter with a one-cycle-latency RAM model.
module tb_hub75_fb_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 24;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_cmp   = 0;
  int   n_fail  = 0;

  hub75_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  hub75_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD_BURST(8)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  // RAM contents are a fixed function of the full address.
  function automatic logic [23:0] pattern(input logic [11:0] a);
    return {a ^ 12'hA5C, a};
  endfunction

  // RAM model: read data appears the cycle after ram_en.
  always @(posedge sys_clk) begin
    if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= pattern(bus.ram_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic two_gnt;
    bus.rd_req = 0; bus.rd_addr = '0; bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.swap_req = 0; bus.frame_begin = 0; bus.ram_rdata = '0;

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_rd_gnt",  bus.rd_gnt, 0);
    check("rst_ram_en",  bus.ram_en, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_front",   bus.front_bank, 0);
    check("rst_pending", bus.swap_pending, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    rst_n = 1;
    step();

    // 1. Lone read
    bus.rd_addr = 11'd5; bus.rd_req = 1; #1;
    check("t1_rd_gnt", bus.rd_gnt, 1);
    check("t1_wr_gnt", bus.wr_gnt, 0);
    step(); bus.rd_req = 0; #1;
    check("t1_ram_en",   bus.ram_en, 1);
    check("t1_ram_we",   bus.ram_we, 0);
    check("t1_ram_addr", bus.ram_addr, 12'h005);
    check("t1_no_valid", bus.rd_valid, 0);
    step();
    check("t1_rd_valid", bus.rd_valid, 1);
    check("t1_rd_data",  bus.rd_data, pattern(12'h005));
    check("t1_en_off",   bus.ram_en, 0);
    step();
    check("t1_valid_off", bus.rd_valid, 0);

    // 2. Lone write goes to the back bank
    bus.wr_addr = 11'd5; bus.wr_data = 24'hABCDEF; bus.wr_req = 1; #1;
    check("t2_wr_gnt", bus.wr_gnt, 1);
    check("t2_rd_gnt", bus.rd_gnt, 0);
    step(); bus.wr_req = 0; #1;
    check("t2_ram_en",    bus.ram_en, 1);
    check("t2_ram_we",    bus.ram_we, 1);
    check("t2_ram_addr",  bus.ram_addr, 12'h805);
    check("t2_ram_wdata", bus.ram_wdata, 24'hABCDEF);
    step();
    check("t2_en_off", bus.ram_en, 0);
    check("t2_no_resp", bus.rd_valid, 0);

    // 3. Continuous contention: 8 reads then 1 write, repeating
    bus.rd_addr = 11'd7; bus.wr_addr = 11'd9; bus.wr_data = 24'h123456;
    bus.rd_req = 1; bus.wr_req = 1; #1;
    two_gnt = 0;
    for (int k = 0; k < 27; k++) begin
      check($sformatf("t3_rd_gnt_%0d", k), bus.rd_gnt, (k % 9) != 8);
      check($sformatf("t3_wr_gnt_%0d", k), bus.wr_gnt, (k % 9) == 8);
      if (bus.rd_gnt && bus.wr_gnt) two_gnt = 1;
      step();
    end
    check("t3_two_gnt", two_gnt, 0);
    bus.rd_req = 0; bus.wr_req = 0;
    step(); step();

    // 4. Swap with a read in flight at the frame boundary, writes stalled
    bus.wr_addr = 11'h00A; bus.wr_data = 24'h0F0F0F; bus.wr_req = 1; bus.swap_req = 1; #1;
    check("t4_wr_stall_req", bus.wr_gnt, 0);
    step(); bus.swap_req = 0; #1;
    check("t4_pending", bus.swap_pending, 1);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t4_wr_stall_%0d", k), bus.wr_gnt, 0);
      step();
    end
    bus.rd_addr = 11'd3; bus.rd_req = 1; #1;
    check("t4_rd_gnt_pend", bus.rd_gnt, 1);
    check("t4_wr_stall_rd", bus.wr_gnt, 0);
    step(); bus.rd_req = 0; bus.frame_begin = 1; #1;
    check("t4_rd_addr_old", bus.ram_addr, 12'h003);
    check("t4_wr_stall_fb", bus.wr_gnt, 0);
    step(); bus.frame_begin = 0; bus.rd_addr = 11'd4; bus.rd_req = 1; #1;
    check("t4_rd_valid",    bus.rd_valid, 1);
    check("t4_rd_data",     bus.rd_data, pattern(12'h003));
    check("t4_done_wait",   bus.swap_done, 0);
    check("t4_rd_supp0",    bus.rd_gnt, 0);
    check("t4_wr_stall_d0", bus.wr_gnt, 0);
    step();
    check("t4_swap_done",   bus.swap_done, 1);
    check("t4_rd_supp1",    bus.rd_gnt, 0);
    check("t4_wr_stall_d1", bus.wr_gnt, 0);
    check("t4_front_old",   bus.front_bank, 0);
    check("t4_pend_done",   bus.swap_pending, 1);
    step();
    check("t4_front_new",   bus.front_bank, 1);
    check("t4_pend_clr",    bus.swap_pending, 0);
    check("t4_done_off",    bus.swap_done, 0);
    check("t4_rd_first",    bus.rd_gnt, 1);
    check("t4_wr_second",   bus.wr_gnt, 0);
    step(); bus.rd_req = 0; #1;
    check("t4_rd_addr_new", bus.ram_addr, 12'h804);
    check("t4_wr_gnt",      bus.wr_gnt, 1);
    step(); bus.wr_req = 0; #1;
    check("t4_rd_valid_new", bus.rd_valid, 1);
    check("t4_rd_data_new",  bus.rd_data, pattern(12'h804));
    check("t4_wr_we",        bus.ram_we, 1);
    check("t4_wr_addr",      bus.ram_addr, 12'h00A);
    check("t4_wr_wdata",     bus.ram_wdata, 24'h0F0F0F);
    step(); step();

    // frame_begin with nothing pending has no effect
    bus.frame_begin = 1; #1;
    step(); bus.frame_begin = 0; #1;
    check("fb_only_pend",  bus.swap_pending, 0);
    check("fb_only_done",  bus.swap_done, 0);
    check("fb_only_front", bus.front_bank, 1);

    // 5. swap_req and frame_begin together on an idle bus
    bus.swap_req = 1; bus.frame_begin = 1; #1;
    step(); bus.swap_req = 0; bus.frame_begin = 0; #1;
    check("t5_swap_done",   bus.swap_done, 1);
    check("t5_front_still", bus.front_bank, 1);
    step();
    check("t5_front_toggled", bus.front_bank, 0);
    check("t5_done_off",      bus.swap_done, 0);
    check("t5_pend_clr",      bus.swap_pending, 0);

    // 6. Reset during a read: response dropped, front bank back to 0
    bus.swap_req = 1; bus.frame_begin = 1; #1;
    step(); bus.swap_req = 0; bus.frame_begin = 0;
    step();
    check("t6_front_pre", bus.front_bank, 1);
    bus.rd_addr = 11'd2; bus.rd_req = 1; #1;
    check("t6_rd_gnt", bus.rd_gnt, 1);
    step();
    check("t6_ram_en_pre", bus.ram_en, 1);
    rst_n = 0; #1;
    check("t6_rd_gnt_rst", bus.rd_gnt, 0);
    check("t6_ram_en",     bus.ram_en, 0);
    check("t6_ram_addr",   bus.ram_addr, 0);
    check("t6_rd_valid",   bus.rd_valid, 0);
    check("t6_front",      bus.front_bank, 0);
    step();
    check("t6_no_valid_rst", bus.rd_valid, 0);
    bus.rd_req = 0; rst_n = 1;
    step();
    check("t6_no_valid_after", bus.rd_valid, 0);
    check("t6_front_after",    bus.front_bank, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
